// File: rtl/ws2812_in_pkg.sv
// ws2812_in_pkg: shared types and constants for the WS2812 receiver.
// Define WS2812_IN_RGBW_EN for 4 bytes per LED (G,R,B,W), else 3 (G,R,B).
package ws2812_in_pkg;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    localparam logic [3:0] SLOT_G = 4'b0001;
    localparam logic [3:0] SLOT_R = 4'b0010;
    localparam logic [3:0] SLOT_B = 4'b0100;
    localparam logic [3:0] SLOT_W = 4'b1000;

`ifdef WS2812_IN_RGBW_EN
    localparam int unsigned BYTES_PER_LED = 4;
`else
    localparam int unsigned BYTES_PER_LED = 3;
`endif

    localparam logic [1:0] LAST_SLOT = 2'(BYTES_PER_LED - 1);

    // Slot index to one-hot byte enable; W only exists in RGBW builds.
    function automatic logic [3:0] slot_en(input logic [1:0] s);
        logic [3:0] en;
        en = 4'b0000;
        unique case (s)
            2'd0: en = SLOT_G;
            2'd1: en = SLOT_R;
            2'd2: en = SLOT_B;
`ifdef WS2812_IN_RGBW_EN
            2'd3: en = SLOT_W;
`else
            2'd3: en = 4'b0000;
`endif
            default: en = 4'b0000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/ws2812_in_sync.sv
// ws2812_in_sync: 2-flop synchroniser for the WS2812 line plus edge strobes.
// Ports: clk, rst (async high), din (async line), lvl (synced), rise, fall.
module ws2812_in_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign lvl  = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/ws2812_in.sv
// ws2812_in: WS2812 line receiver; decodes bits by high width, emits GRB(W)
// bytes with slot/LED address, and flags frame end on the latch gap.
// Ports: clk_in, rst_in (async high), ws2812_data_in; byte_vld_out,
// byte_data_out, byte_en_out, wr_addr_out, frame_rdy_out, led_cnt_out, err_out.
// Macro WS2812_IN_RGBW_EN selects 4 bytes per LED (see ws2812_in_pkg).
module ws2812_in #(
    parameter int unsigned BIT_THRESH_CYC = 48,
    parameter int unsigned GLITCH_CYC     = 8,
    parameter int unsigned HIGH_MAX_CYC   = 120,
    parameter int unsigned RST_GAP_CYC    = 4000,
    parameter int unsigned MAX_LEDS       = 64
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ws2812_data_in,
    output logic       byte_vld_out,
    output logic [7:0] byte_data_out,
    output logic [3:0] byte_en_out,
    output logic [5:0] wr_addr_out,
    output logic       frame_rdy_out,
    output logic [6:0] led_cnt_out,
    output logic       err_out
);
    import ws2812_in_pkg::*;

    localparam logic [12:0] T_BIT  = 13'(BIT_THRESH_CYC);
    localparam logic [12:0] T_GL   = 13'(GLITCH_CYC);
    localparam logic [12:0] T_HMAX = 13'(HIGH_MAX_CYC);
    localparam logic [12:0] T_GAP  = 13'(RST_GAP_CYC - 1);
    localparam logic [6:0]  N_LED  = 7'(MAX_LEDS);

    state_t      state;
    state_t      nxt;
    logic [12:0] cnt;
    logic        pend;
    logic        lvl;
    logic        rise;
    logic        fall;
    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic [1:0]  slot;
    logic [6:0]  led_idx;
    logic        any_byte;

    logic start;
    logic take_bit;
    logic bit_val;
    logic overlong;
    logic gap_end;
    logic arm_done;
    logic full;

    ws2812_in_sync u_sync (
        .clk  (clk_in),
        .rst  (rst_in),
        .din  (ws2812_data_in),
        .lvl  (lvl),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= ARM;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ARM:  if (arm_done) nxt = IDLE;
            IDLE: if (start) nxt = HIGH;
            HIGH: begin
                if (overlong)  nxt = ARM;
                else if (fall) nxt = LOW;
            end
            LOW: begin
                if (gap_end)   nxt = IDLE;
                else if (rise) nxt = HIGH;
            end
            default: nxt = ARM;
        endcase
    end

    // pend: an edge that coincided with frame end starts the next frame.
    always_comb begin
        start    = 1'b0;
        take_bit = 1'b0;
        overlong = 1'b0;
        gap_end  = 1'b0;
        arm_done = 1'b0;
        unique case (state)
            ARM:  arm_done = !lvl && (cnt == T_GAP);
            IDLE: start    = rise | (pend & lvl);
            HIGH: begin
                take_bit = fall && (cnt >= T_GL);
                overlong = !fall && (cnt >= T_HMAX);
            end
            LOW:  gap_end  = (cnt == T_GAP);
            default: ;
        endcase
    end

    assign bit_val = (cnt >= T_BIT);
    assign full    = (led_idx == N_LED);

    // cnt: low cycles in ARM/LOW, high cycles in HIGH.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else begin
            pend <= gap_end & rise;
            unique case (state)
                ARM: begin
                    if (lvl || arm_done) cnt <= '0;
                    else                 cnt <= cnt + 13'd1;
                end
                IDLE: begin
                    if (start) cnt <= pend ? 13'd2 : 13'd1;
                    else       cnt <= '0;
                end
                HIGH: begin
                    if (fall)            cnt <= 13'd1;
                    else if (overlong)   cnt <= '0;
                    else if (cnt != '1)  cnt <= cnt + 13'd1;
                end
                LOW: begin
                    if (gap_end)   cnt <= '0;
                    else if (rise) cnt <= 13'd1;
                    else           cnt <= cnt + 13'd1;
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            shreg         <= '0;
            bit_cnt       <= '0;
            slot          <= '0;
            led_idx       <= '0;
            any_byte      <= 1'b0;
            byte_vld_out  <= 1'b0;
            byte_data_out <= '0;
            byte_en_out   <= '0;
            wr_addr_out   <= '0;
            frame_rdy_out <= 1'b0;
            led_cnt_out   <= '0;
            err_out       <= 1'b0;
        end else begin
            byte_vld_out  <= 1'b0;
            frame_rdy_out <= 1'b0;
            if (start) begin
                err_out  <= 1'b0;
                bit_cnt  <= '0;
                slot     <= '0;
                led_idx  <= '0;
                any_byte <= 1'b0;
            end
            if (take_bit) begin
                shreg   <= {shreg[6:0], bit_val};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (full) begin
                        err_out <= 1'b1;
                    end else begin
                        byte_vld_out  <= 1'b1;
                        byte_data_out <= {shreg[6:0], bit_val};
                        byte_en_out   <= slot_en(slot);
                        wr_addr_out   <= led_idx[5:0];
                        any_byte      <= 1'b1;
                        if (slot == LAST_SLOT) begin
                            slot    <= '0;
                            led_idx <= led_idx + 7'd1;
                        end else begin
                            slot <= slot + 2'd1;
                        end
                    end
                end
            end
            if (overlong) err_out <= 1'b1;
            if (gap_end) begin
                if (bit_cnt != 3'd0) err_out <= 1'b1;
                if (any_byte) begin
                    frame_rdy_out <= 1'b1;
                    led_cnt_out   <= led_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_ws2812_in.sv
// tb_ws2812_in: directed-vector bench for ws2812_in (default 3-byte build).
// Collects strobes in a monitor and compares against hand-computed values.
module tb_ws2812_in;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       ws2812_data_in;
    logic       byte_vld_out;
    logic [7:0] byte_data_out;
    logic [3:0] byte_en_out;
    logic [5:0] wr_addr_out;
    logic       frame_rdy_out;
    logic [6:0] led_cnt_out;
    logic       err_out;

    ws2812_in dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .ws2812_data_in (ws2812_data_in),
        .byte_vld_out   (byte_vld_out),
        .byte_data_out  (byte_data_out),
        .byte_en_out    (byte_en_out),
        .wr_addr_out    (wr_addr_out),
        .frame_rdy_out  (frame_rdy_out),
        .led_cnt_out    (led_cnt_out),
        .err_out        (err_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errs   = 0;
    int nfrm     = 0;
    int t1h = 64, t1l = 36, t0h = 28, t0l = 72;

    logic [7:0] qd[$];
    logic [3:0] qe[$];
    logic [5:0] qa[$];

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (byte_vld_out) begin
                qd.push_back(byte_data_out);
                qe.push_back(byte_en_out);
                qa.push_back(wr_addr_out);
            end
            if (frame_rdy_out) nfrm = nfrm + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_bit(input logic b);
        ws2812_data_in = 1'b1;
        cyc(b ? t1h : t0h);
        ws2812_data_in = 1'b0;
        cyc(b ? t1l : t0l);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic gap(input int n);
        ws2812_data_in = 1'b0;
        cyc(n);
    endtask

    task automatic clr();
        qd.delete();
        qe.delete();
        qa.delete();
        nfrm = 0;
    endtask

    function automatic logic [31:0] qd_at(input int i);
        return (i < qd.size()) ? 32'(qd[i]) : 32'hxxxx_xxxx;
    endfunction

    logic [3:0] en_exp [6];
    logic [5:0] ad_exp [6];
    logic [7:0] v;

    initial begin
        en_exp = '{4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h4};
        ad_exp = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 6'd1};
        rst_in = 1'b1;
        ws2812_data_in = 1'b0;
        cyc(4);
        rst_in = 1'b0;
        cyc(1);
        check("rst_vld", 32'(byte_vld_out), 0);
        check("rst_frm", 32'(frame_rdy_out), 0);
        check("rst_err", 32'(err_out), 0);
        check("rst_lcnt", 32'(led_cnt_out), 0);
        check("rst_en", 32'(byte_en_out), 0);
        check("rst_addr", 32'(wr_addr_out), 0);

        // single byte 0xA5
        gap(4010);
        clr();
        send_byte(8'hA5);
        gap(4010);
        check("a5_n", qd.size(), 1);
        check("a5_data", qd_at(0), 32'hA5);
        check("a5_en", (qe.size() > 0) ? 32'(qe[0]) : 'x, 1);
        check("a5_addr", (qa.size() > 0) ? 32'(qa[0]) : 'x, 0);
        check("a5_frm", nfrm, 1);
        check("a5_lcnt", 32'(led_cnt_out), 0);
        check("a5_err", 32'(err_out), 0);

        // two LEDs
        clr();
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        gap(4010);
        check("six_n", qd.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check("six_data", qd_at(i), 32'(i + 1));
            check("six_en", (i < qe.size()) ? 32'(qe[i]) : 'x,
                  32'(en_exp[i]));
            check("six_addr", (i < qa.size()) ? 32'(qa[i]) : 'x,
                  32'(ad_exp[i]));
        end
        check("six_lcnt", 32'(led_cnt_out), 2);
        check("six_frm", nfrm, 1);
        check("six_err", 32'(err_out), 0);

        // short glitch after every bit
        clr();
        v = 8'h3C;
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
            ws2812_data_in = 1'b1;
            cyc(4);
            ws2812_data_in = 1'b0;
            cyc(40);
        end
        gap(4010);
        check("gl_n", qd.size(), 1);
        check("gl_data", qd_at(0), 32'h3C);
        check("gl_err", 32'(err_out), 0);

        // 12 bits: one byte plus a partial
        clr();
        send_byte(8'h5A);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        gap(4010);
        check("part_n", qd.size(), 1);
        check("part_data", qd_at(0), 32'h5A);
        check("part_frm", nfrm, 1);
        check("part_err", 32'(err_out), 1);
        check("part_lcnt", 32'(led_cnt_out), 0);

        // line high through reset; no decode before a full gap
        ws2812_data_in = 1'b1;
        rst_in = 1'b1;
        cyc(3);
        rst_in = 1'b0;
        cyc(1);
        check("rh_err0", 32'(err_out), 0);
        check("rh_lcnt0", 32'(led_cnt_out), 0);
        clr();
        cyc(300);
        gap(200);
        send_byte(8'hA5);
        gap(4010);
        check("rh_n", qd.size(), 0);
        check("rh_frm", nfrm, 0);
        check("rh_err", 32'(err_out), 0);

        // overlong high mid-frame
        clr();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ws2812_data_in = 1'b1;
        cyc(200);
        gap(100);
        send_byte(8'hFF);
        gap(4010);
        check("ol_n", qd.size(), 0);
        check("ol_frm", nfrm, 0);
        check("ol_err", 32'(err_out), 1);
        clr();
        send_byte(8'h81);
        gap(4010);
        check("ol_rec_n", qd.size(), 1);
        check("ol_rec_data", qd_at(0), 32'h81);
        check("ol_rec_err", 32'(err_out), 0);
        check("ol_rec_frm", nfrm, 1);

        // 65 LEDs: overflow, fast bit timing
        t1h = 50; t1l = 4; t0h = 10; t0l = 4;
        clr();
        for (int i = 0; i < 195; i++)
            send_byte((i == 0 || i == 191) ? 8'hC3 : 8'h00);
        gap(4010);
        check("ovf_n", qd.size(), 192);
        check("ovf_first", qd_at(0), 32'hC3);
        check("ovf_last", qd_at(191), 32'hC3);
        check("ovf_addr", (qa.size() > 0) ? 32'(qa[$]) : 'x, 63);
        check("ovf_en", (qe.size() > 0) ? 32'(qe[$]) : 'x, 4);
        check("ovf_lcnt", 32'(led_cnt_out), 64);
        check("ovf_err", 32'(err_out), 1);
        check("ovf_frm", nfrm, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ws2812_in.md
Name: ws2812_in

Overview:
WS2812 receiver. Samples an incoming single-wire WS2812 stream, decodes bits by high-pulse width, assembles GRB bytes and LED addresses, and flags frame end on the latch gap. It sits at a board input and feeds the layer buffer write side (byte/address/frame-ready), the counterpart of the ws2812 output path.

Parameters:
BIT_THRESH_CYC, 48, high width (clk cycles) at or above which a bit decodes as 1 (600 ns at 80 MHz)
GLITCH_CYC, 8, high pulses shorter than this are ignored
HIGH_MAX_CYC, 120, high longer than this is a line error
RST_GAP_CYC, 4000, low time that ends a frame / arms the receiver (50 us at 80 MHz)
MAX_LEDS, 64, LEDs accepted per frame; further bytes dropped

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-high reset
ws2812_data_in  input  1  asynchronous WS2812 line
byte_vld_out  output  1  one-cycle strobe, byte_data_out valid
byte_data_out  output  8  decoded byte, MSB received first
byte_en_out  output  4  one-hot colour slot: 0001=G, 0010=R, 0100=B, 1000=W
wr_addr_out  output  6  LED index of current byte
frame_rdy_out  output  1  one-cycle strobe at frame end (at least 1 byte received)
led_cnt_out  output  7  LEDs completed in last frame, held until next frame_rdy_out
err_out  output  1  sticky: glitch-free protocol error (partial byte, overlong high, overflow); cleared at next frame start

Behaviour:
- Reset: all outputs 0; FSM ARM; counters 0.
- Input: 2-flop synchroniser, then registered edge detect; decode latency counts from synchronised edge.
- FSM ARM: count consecutive low cycles; any high clears count; at RST_GAP_CYC -> IDLE. Guarantees no mid-frame start after reset or error.
- IDLE: rising edge -> HIGH, high counter = 1; clear err_out, byte/led counters.
- HIGH: count (saturating). Count > HIGH_MAX_CYC -> err_out=1, ARM. Falling edge: count < GLITCH_CYC -> back to LOW without shifting; else shift bit (count >= BIT_THRESH_CYC) into shift reg, -> LOW.
- LOW: count low cycles; rising edge -> HIGH; count == RST_GAP_CYC -> frame end, IDLE.
- Byte complete (8th bit): byte_vld_out high exactly 1 cycle, the cycle after the synchronised falling edge is detected; byte_en_out slot advances G->R->B(->W) then wraps to G and wr_addr_out increments.
- LED index == MAX_LEDS: bytes not strobed, err_out=1, decoding continues until gap.
- Frame end: partial byte (1-7 bits) discarded, err_out=1; frame_rdy_out 1 cycle iff >=1 byte strobed; led_cnt_out = completed LEDs (0..64, partial LED not counted).
- Frame end and rising edge same cycle: frame end wins, edge starts next frame from IDLE.
- Reset mid-frame: immediate return to ARM, no strobes.

Optional Feature:
WS2812_IN_RGBW_EN: defined -> 4 bytes per LED (G,R,B,W), byte_en_out uses bit 3. Undefined -> 3 bytes per LED, byte_en_out[3] tied 0.

Decomposition:
- Package ws2812_in_pkg: FSM state enum (ARM, IDLE, HIGH, LOW), colour-slot one-hot constants, bytes-per-LED constant selected by the macro.
- Sub-module ws2812_in_sync: 2-flop synchroniser plus rise/fall strobes.

Test Plan:
- Reset, line low 4000 cyc, send 8 bits of 0xA5 (1 = 64 cyc high/36 low, 0 = 28 high/72 low), then 4000 low -> byte_vld_out once with 0xA5, byte_en_out=0001, wr_addr_out=0, frame_rdy_out pulse, led_cnt_out=0, err_out=0.
- Send 6 bytes 0x01..0x06 + gap -> strobes with byte_en_out 1,2,4,1,2,4, wr_addr_out 0,0,0,1,1,1; led_cnt_out=2.
- Insert 4-cycle high glitch between bits -> ignored, bytes unchanged, err_out=0.
- 12 bits then gap -> one byte strobed, partial discarded, err_out=1, frame_rdy_out pulses.
- Line high from reset / 200-cycle high mid-frame -> no strobes, err_out=1 on overlong, no decode until 4000 low cycles seen.
- 65 LEDs (195 bytes) -> 192 strobes, wr_addr_out ends 63, led_cnt_out=64, err_out=1.
